// File: rtl/spike_fifo_ctrl_if.sv
// Handshake/bus bundle between a spike source and spike_fifo_ctrl.
// The master side pushes, pops and flushes; the slave side is the FIFO.
interface spike_fifo_ctrl_if #(
    parameter int B = 8,
    parameter int W = 4
) ();
    logic         flush;
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic [W:0]   count;
    logic         ovf;
    logic         udf;

    modport master (
        output flush, wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full, count, ovf, udf
    );

    modport slave (
        input  flush, wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full, count, ovf, udf
    );
endinterface

// File: rtl/spike_fifo_ctrl.sv
// Spike-event FIFO with occupancy count, almost-full/empty levels and synchronous flush.
// Define SPIKE_FIFO_ERR_EN to enable the sticky ovf/udf error flags (otherwise tied to 0).
module spike_fifo_ctrl #(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset_input_queue,
    spike_fifo_ctrl_if.slave  bus
);
    localparam int         DEPTH     = 1 << W;
    localparam logic [W:0] DEPTH_CNT = DEPTH[W:0];
    localparam logic [W:0] AF_CNT    = AF_LEVEL[W:0];
    localparam logic [W:0] AE_CNT    = AE_LEVEL[W:0];

    logic [B-1:0] mem [0:DEPTH-1];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic [W:0]   count;
    logic         is_empty;
    logic         is_full;
    logic         rd_acc;
    logic         wr_acc;

    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_CNT);
    assign rd_acc   = bus.rd & ~is_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign wr_acc   = bus.wr & (~is_full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc && !bus.flush) begin
            mem[wr_ptr] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or posedge reset_input_queue) begin
        if (reset_input_queue) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SPIKE_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Flush wins over a same-cycle error so the flags come out cleared.
    always_ff @(posedge clk or posedge reset_input_queue) begin
        if (reset_input_queue) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.wr && is_full && !bus.rd) begin
                ovf_q <= 1'b1;
            end
            if (bus.rd && is_empty) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf = ovf_q;
    assign bus.udf = udf_q;
`else
    assign bus.ovf = 1'b0;
    assign bus.udf = 1'b0;
`endif

    assign bus.r_data       = is_empty ? '0 : mem[rd_ptr];
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (count <= AE_CNT);
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.count        = count;
endmodule
